evt_pkt_parser: RTL and testbench

//  Receive-side counterpart of the event-capture packet writer. Sits inline in the user data path,

---
 rtl/evt_pkt_parser_pkg.sv | 33 +++
 rtl/evt_dec_fifo.sv | 62 ++++++
 rtl/evt_pkt_parser.sv | 204 ++++++++++++++++++++
 tb/tb_evt_pkt_parser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkt_parser_pkg.sv
// Shared event-capture definitions: record type codes, packet identification constants and
// record/info field positions, common to the packet writer and this parser.
package evt_pkt_parser_pkg;

    localparam logic [1:0]  EC_TYPE_TIME_SET = 2'b00;
    localparam logic [1:0]  EC_TYPE_EVT_A    = 2'b01;
    localparam logic [1:0]  EC_TYPE_EVT_B    = 2'b10;
    localparam logic [1:0]  EC_TYPE_EVT_C    = 2'b11;

    localparam logic [15:0] EC_ETHERTYPE     = 16'h9999;
    localparam logic [3:0]  EC_VERSION       = 4'h1;
    localparam logic [7:0]  EC_MOD_HDR_CTRL  = 8'hFF;

    localparam int EC_REC_WIDTH      = 32;
    localparam int EC_REC_TYPE_LSB   = 30;
    localparam int EC_ETHERTYPE_LSB  = 16;
    localparam int EC_VERSION_LSB    = 60;
    localparam int EC_NUM_EVTS_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_INFO,
        ST_REGS,
        ST_EVTS,
        ST_SKIP
    } parse_state_t;

    function automatic logic is_time_set(input logic [1:0] rec_type);
        return rec_type == EC_TYPE_TIME_SET;
    endfunction

endpackage

// File: rtl/evt_dec_fifo.sv
// First-word-fall-through FIFO for decoded events: up to two writes and one read per cycle.
// Two write ports rule out block RAM, so storage is a register array read combinationally.
module evt_dec_fifo #(
    parameter int WIDTH      = 45,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            wr_en,
    input  logic [WIDTH-1:0]      wr_data0,
    input  logic [WIDTH-1:0]      wr_data1,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_BITS:0]   free_slots
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg;
    logic [DEPTH_BITS-1:0] wr_ptr_p1;
    logic [DEPTH_BITS-1:0] rd_ptr_reg;
    logic [DEPTH_BITS:0]   count_reg;
    logic [1:0]            n_push;
    logic                  pop;
    logic [WIDTH-1:0]      first_data;

    // A lone write on port 1 is compacted into the head slot so entries stay in order.
    assign n_push     = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    assign first_data = wr_en[0] ? wr_data0 : wr_data1;
    assign wr_ptr_p1  = wr_ptr_reg + DEPTH_BITS'(1);
    assign pop        = rd_en && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wr_ptr_reg] <= first_data;
        end
        if (n_push == 2'd2) begin
            mem[wr_ptr_p1] <= wr_data1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + DEPTH_BITS'(n_push);
            rd_ptr_reg <= rd_ptr_reg + DEPTH_BITS'(pop);
            count_reg  <= count_reg + (DEPTH_BITS+1)'(n_push) - (DEPTH_BITS+1)'(pop);
        end
    end

    assign rd_data    = mem[rd_ptr_reg];
    assign rd_valid   = (count_reg != '0);
    assign free_slots = (DEPTH_BITS+1)'(DEPTH) - count_reg;

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        (int'(count_reg) + int'(n_push) - int'(pop)) <= DEPTH);

endmodule

// File: rtl/evt_pkt_parser.sv
// Inline event-capture packet parser: passes the datapath through untouched while decoding
// event records into a buffered stream with absolute timestamps and flagging malformed packets.
module evt_pkt_parser
    import evt_pkt_parser_pkg::*;
#(
    parameter int          DATA_WIDTH          = 64,
    parameter int          CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int          HEADER_LENGTH       = 7,
    parameter int          NUM_ABS_REG_PAIRS   = 4,
    parameter int          SIGNAL_ID_SIZE      = 3,
    parameter int          SIG_VALUE_SIZE      = 8,
    parameter logic [15:0] EVT_ETHERTYPE       = EC_ETHERTYPE,
    parameter logic [3:0]  EVT_CAPTURE_VERSION = EC_VERSION,
    parameter int          EVT_FIFO_DEPTH_BITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    input  logic                      in_wr,
    output logic                      in_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      out_wr,
    input  logic                      out_rdy,
    output logic                      evt_valid,
    input  logic                      evt_rdy,
    output logic [1:0]                evt_type,
    output logic [SIGNAL_ID_SIZE-1:0] evt_sig_id,
    output logic [SIG_VALUE_SIZE-1:0] evt_value,
    output logic [31:0]               evt_time,
    output logic [15:0]               evt_pkt_cnt,
    output logic                      ver_err,
    output logic                      len_err
);
    localparam int DELTA_SIZE = EC_REC_WIDTH - 2 - SIGNAL_ID_SIZE - SIG_VALUE_SIZE;
    localparam int EVT_WIDTH  = 2 + SIGNAL_ID_SIZE + SIG_VALUE_SIZE + 32;
    localparam int SIG_ID_LSB = EC_REC_TYPE_LSB - SIGNAL_ID_SIZE;
    localparam int VALUE_LSB  = SIG_ID_LSB - SIG_VALUE_SIZE;

    assign out_data = in_data;
    assign out_ctrl = in_ctrl;
    assign out_wr   = in_wr;

    parse_state_t                 state_reg;
    logic [7:0]                   word_cnt_reg;
    logic [EC_NUM_EVTS_WIDTH-1:0] remaining_reg;
    logic [EC_NUM_EVTS_WIDTH-1:0] remaining_next;
    logic [31:0]                  time_base_reg;
    logic [31:0]                  time_base_next;
    logic [15:0]                  pkt_cnt_reg;
    logic                         ver_err_reg;
    logic                         len_err_reg;

    logic                         is_mod_hdr;
    logic                         is_eop;
    logic                         evts_word;
    logic [3:0]                   info_version;
    logic [EC_NUM_EVTS_WIDTH-1:0] info_num_evts;

    assign is_mod_hdr    = (in_ctrl == CTRL_WIDTH'(EC_MOD_HDR_CTRL));
    assign is_eop        = (in_ctrl != '0);
    assign evts_word     = in_wr && (state_reg == ST_EVTS);
    assign info_version  = in_data[EC_VERSION_LSB +: 4];
    assign info_num_evts = in_data[EC_NUM_EVTS_WIDTH-1:0];

    // Lane 0 is the upper record (first in time), lane 1 the lower one.
    logic [31:0]          rec      [2];
    logic [31:0]          rec_base [2];
    logic [EVT_WIDTH-1:0] rec_evt  [2];
    logic [1:0]           rec_use;
    logic [1:0]           rec_ts;
    logic [1:0]           rec_push;

    // A time-set in the upper lane rebases the lower lane within the same word.
    assign rec_base[0] = time_base_reg;
    assign rec_base[1] = rec_ts[0] ? {2'b00, rec[0][29:0]} : time_base_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign rec[gi]      = in_data[DATA_WIDTH-1-EC_REC_WIDTH*gi -: EC_REC_WIDTH];
            assign rec_use[gi]  = evts_word && (remaining_reg > EC_NUM_EVTS_WIDTH'(gi));
            assign rec_ts[gi]   = rec_use[gi] && is_time_set(rec[gi][31:30]);
            assign rec_push[gi] = rec_use[gi] && !rec_ts[gi];
            assign rec_evt[gi]  = {rec[gi][31:30],
                                   rec[gi][SIG_ID_LSB +: SIGNAL_ID_SIZE],
                                   rec[gi][VALUE_LSB +: SIG_VALUE_SIZE],
                                   rec_base[gi] + 32'(rec[gi][DELTA_SIZE-1:0])};
        end
    endgenerate

    assign time_base_next = rec_ts[1] ? {2'b00, rec[1][29:0]} : rec_base[1];
    assign remaining_next = remaining_reg - EC_NUM_EVTS_WIDTH'(rec_use[0])
                                          - EC_NUM_EVTS_WIDTH'(rec_use[1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            word_cnt_reg  <= '0;
            remaining_reg <= '0;
            time_base_reg <= '0;
            pkt_cnt_reg   <= '0;
            ver_err_reg   <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            ver_err_reg <= 1'b0;
            len_err_reg <= 1'b0;
            if (in_wr) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (is_mod_hdr) begin
                            state_reg    <= ST_HDR;
                            word_cnt_reg <= 8'd1;
                        end
                    end
                    ST_HDR: begin
                        if (is_eop) begin
                            len_err_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end else if (word_cnt_reg == 8'd2 &&
                                     in_data[EC_ETHERTYPE_LSB +: 16] != EVT_ETHERTYPE) begin
                            state_reg <= ST_SKIP;
                        end else if (word_cnt_reg == 8'(HEADER_LENGTH)) begin
                            state_reg <= ST_INFO;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 8'd1;
                        end
                    end
                    ST_INFO: begin
                        if (info_version != EVT_CAPTURE_VERSION) begin
                            ver_err_reg <= 1'b1;
                            state_reg   <= is_eop ? ST_IDLE : ST_SKIP;
                        end else if (info_num_evts == '0) begin
                            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                            state_reg   <= is_eop ? ST_IDLE : ST_SKIP;
                        end else if (is_eop) begin
                            len_err_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end else begin
                            remaining_reg <= info_num_evts;
                            word_cnt_reg  <= 8'd1;
                            state_reg     <= (NUM_ABS_REG_PAIRS == 0) ? ST_EVTS : ST_REGS;
                        end
                    end
                    ST_REGS: begin
                        if (is_eop) begin
                            len_err_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end else if (word_cnt_reg == 8'(NUM_ABS_REG_PAIRS)) begin
                            state_reg <= ST_EVTS;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 8'd1;
                        end
                    end
                    ST_EVTS: begin
                        remaining_reg <= remaining_next;
                        time_base_reg <= time_base_next;
                        if (remaining_next == '0) begin
                            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                            state_reg   <= is_eop ? ST_IDLE : ST_SKIP;
                        end else if (is_eop) begin
                            len_err_reg <= 1'b1;
                            state_reg   <= ST_IDLE;
                        end
                    end
                    ST_SKIP: begin
                        if (is_eop) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    logic [EVT_WIDTH-1:0]         evt_head;
    logic [EVT_FIFO_DEPTH_BITS:0] fifo_free;

    evt_dec_fifo #(
        .WIDTH      (EVT_WIDTH),
        .DEPTH_BITS (EVT_FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (rec_push),
        .wr_data0   (rec_evt[0]),
        .wr_data1   (rec_evt[1]),
        .rd_en      (evt_rdy),
        .rd_data    (evt_head),
        .rd_valid   (evt_valid),
        .free_slots (fifo_free)
    );

    // Every accepted word can push two records, so keep two slots in reserve.
    assign in_rdy = out_rdy && (fifo_free >= (EVT_FIFO_DEPTH_BITS+1)'(2));

    assign {evt_type, evt_sig_id, evt_value, evt_time} = evt_head;
    assign evt_pkt_cnt = pkt_cnt_reg;
    assign ver_err     = ver_err_reg;
    assign len_err     = len_err_reg;

endmodule

// File: tb/tb_evt_pkt_parser.sv
// Directed bench for evt_pkt_parser: one task per scenario with hand-computed expectations.
module tb_evt_pkt_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        evt_valid;
    logic        evt_rdy = 1'b1;
    logic [1:0]  evt_type;
    logic [2:0]  evt_sig_id;
    logic [7:0]  evt_value;
    logic [31:0] evt_time;
    logic [15:0] evt_pkt_cnt;
    logic        ver_err;
    logic        len_err;

    evt_pkt_parser dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .evt_valid(evt_valid), .evt_rdy(evt_rdy),
        .evt_type(evt_type), .evt_sig_id(evt_sig_id), .evt_value(evt_value), .evt_time(evt_time),
        .evt_pkt_cnt(evt_pkt_cnt), .ver_err(ver_err), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [44:0] got_q[$];
    int          ver_pulses = 0;
    int          len_pulses = 0;
    logic [63:0] pkt_d[$];
    logic [7:0]  pkt_c[$];
    logic [63:0] evw[$];

    // Popped events and error-pulse cycles are collected away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (evt_valid && evt_rdy) got_q.push_back({evt_type, evt_sig_id, evt_value, evt_time});
            if (ver_err) ver_pulses++;
            if (len_err) len_pulses++;
        end
    end

    function automatic logic [31:0] rec(input logic [1:0] t, input logic [2:0] id,
                                        input logic [7:0] v, input logic [18:0] d);
        return {t, id, v, d};
    endfunction

    function automatic logic [31:0] ts(input logic [29:0] b);
        return {2'b00, b};
    endfunction

    function automatic logic [44:0] ev(input logic [1:0] t, input logic [2:0] id,
                                       input logic [7:0] v, input logic [31:0] tm);
        return {t, id, v, tm};
    endfunction

    function automatic logic [44:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 'x;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic build_pkt(input logic [15:0] etype, input logic [3:0] ver, input logic [8:0] num);
        pkt_d.delete(); pkt_c.delete();
        pkt_d.push_back(64'h0001_0002_0000_0040); pkt_c.push_back(8'hFF);
        pkt_d.push_back(64'h0011_2233_4455_0066); pkt_c.push_back(8'h00);
        pkt_d.push_back({32'h7788_99AA, etype, 16'h4500}); pkt_c.push_back(8'h00);
        for (int i = 3; i <= 7; i++) begin
            pkt_d.push_back(64'hC0DE_0000_0000_0000 | 64'(i)); pkt_c.push_back(8'h00);
        end
        pkt_d.push_back({ver, 51'd0, num}); pkt_c.push_back(8'h00);
        for (int i = 0; i < 4; i++) begin
            pkt_d.push_back(64'hAB00_0000_0000_1000 + 64'(i)); pkt_c.push_back(8'h00);
        end
        foreach (evw[i]) begin
            pkt_d.push_back(evw[i]); pkt_c.push_back(8'h00);
        end
    endtask

    task automatic send_pkt(input bit with_eop);
        for (int i = 0; i < pkt_d.size(); i++) begin
            if (!in_rdy) begin
                int waited;
                waited = 0;
                in_wr = 1'b0;
                while (!in_rdy && waited < 500) begin @(posedge clk); #1; waited++; end
                if (!in_rdy) begin
                    n_checks++;
                    $display("FAIL send_timeout word %0d: in_rdy=%b required 1", i, in_rdy);
                    in_wr = 1'b0;
                    return;
                end
            end
            in_data = pkt_d[i];
            in_ctrl = (with_eop && i == pkt_d.size() - 1) ? 8'h80 : pkt_c[i];
            in_wr   = 1'b1;
            @(posedge clk); #1;
        end
        in_wr = 1'b0;
        in_ctrl = 8'h00;
    endtask

    // Reference good packet: 3 records, one time-set plus two events, padding in the last half.
    task automatic send_good_pkt();
        evw.delete();
        evw.push_back({ts(30'h100), rec(2'b01, 3'd2, 8'h55, 19'd5)});
        evw.push_back({rec(2'b10, 3'd7, 8'hAA, 19'd0), 32'h0000_0000});
        build_pkt(16'h9999, 4'h1, 9'd3);
        send_pkt(1'b1);
        wait_cycles(10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(2);
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid: got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'd0) $display("FAIL reset_pkt_cnt: got %0d want 0", evt_pkt_cnt); else n_pass++;
        n_checks++; if ({ver_err, len_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {ver_err, len_err}); else n_pass++;
        reset = 1'b0;
        wait_cycles(1);
        n_checks++; if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy: got %b want 1", in_rdy); else n_pass++;
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL post_reset_evt_valid: got %b want 0", evt_valid); else n_pass++;
    endtask

    task automatic test_basic();
        int base, p0, v0, l0;
        base = got_q.size(); p0 = evt_pkt_cnt; v0 = ver_pulses; l0 = len_pulses;
        send_good_pkt();
        n_checks++; if (got_q.size() - base != 2) $display("FAIL basic_count: got %0d want 2", got_q.size() - base); else n_pass++;
        n_checks++; if (got_at(base) !== ev(2'b01, 3'd2, 8'h55, 32'h105)) $display("FAIL basic_ev0: got %h want %h", got_at(base), ev(2'b01, 3'd2, 8'h55, 32'h105)); else n_pass++;
        n_checks++; if (got_at(base+1) !== ev(2'b10, 3'd7, 8'hAA, 32'h100)) $display("FAIL basic_ev1: got %h want %h", got_at(base+1), ev(2'b10, 3'd7, 8'hAA, 32'h100)); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'(p0 + 1)) $display("FAIL basic_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0 + 1); else n_pass++;
        n_checks++; if (ver_pulses != v0) $display("FAIL basic_ver_err: got %0d pulses want 0", ver_pulses - v0); else n_pass++;
        n_checks++; if (len_pulses != l0) $display("FAIL basic_len_err: got %0d pulses want 0", len_pulses - l0); else n_pass++;
        $display("basic pkt: %0d events, pkt_cnt=%0d", got_q.size() - base, evt_pkt_cnt);
    endtask

    task automatic test_non_event();
        int base, p0;
        logic [7:0] c;
        base = got_q.size(); p0 = evt_pkt_cnt;
        evw.delete();
        evw.push_back({ts(30'h100), rec(2'b01, 3'd2, 8'h55, 19'd5)});
        evw.push_back({rec(2'b10, 3'd7, 8'hAA, 19'd0), 32'h0000_0000});
        build_pkt(16'h0800, 4'h1, 9'd3);
        for (int i = 0; i < pkt_d.size(); i++) begin
            c = (i == pkt_d.size() - 1) ? 8'h80 : pkt_c[i];
            in_data = pkt_d[i]; in_ctrl = c; in_wr = 1'b1;
            #1;
            n_checks++;
            if ({out_data, out_ctrl, out_wr} !== {pkt_d[i], c, 1'b1})
                $display("FAIL mirror_word%0d: got %h/%h/%b want %h/%h/1", i, out_data, out_ctrl, out_wr, pkt_d[i], c);
            else n_pass++;
            @(posedge clk); #1;
        end
        in_wr = 1'b0; in_ctrl = 8'h00;
        wait_cycles(10);
        n_checks++; if (got_q.size() != base) $display("FAIL nonevt_count: got %0d want 0", got_q.size() - base); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'(p0)) $display("FAIL nonevt_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0); else n_pass++;
        $display("non-event pkt: %0d events, pkt_cnt=%0d", got_q.size() - base, evt_pkt_cnt);
    endtask

    task automatic test_version();
        int base, p0, v0, l0;
        base = got_q.size(); p0 = evt_pkt_cnt; v0 = ver_pulses; l0 = len_pulses;
        evw.delete();
        evw.push_back({ts(30'h100), rec(2'b01, 3'd2, 8'h55, 19'd5)});
        evw.push_back({rec(2'b10, 3'd7, 8'hAA, 19'd0), 32'h0000_0000});
        build_pkt(16'h9999, 4'h2, 9'd3);
        send_pkt(1'b1);
        wait_cycles(10);
        n_checks++; if (ver_pulses - v0 != 1) $display("FAIL ver_pulse: got %0d cycles want 1", ver_pulses - v0); else n_pass++;
        n_checks++; if (got_q.size() != base) $display("FAIL ver_count: got %0d want 0", got_q.size() - base); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'(p0)) $display("FAIL ver_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0); else n_pass++;
        n_checks++; if (len_pulses != l0) $display("FAIL ver_len_err: got %0d pulses want 0", len_pulses - l0); else n_pass++;
        $display("bad-version pkt: ver_err cycles=%0d", ver_pulses - v0);
        send_good_pkt();
        n_checks++; if (got_q.size() - base != 2) $display("FAIL ver_next_count: got %0d want 2", got_q.size() - base); else n_pass++;
        n_checks++; if (got_at(base) !== ev(2'b01, 3'd2, 8'h55, 32'h105)) $display("FAIL ver_next_ev0: got %h want %h", got_at(base), ev(2'b01, 3'd2, 8'h55, 32'h105)); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'(p0 + 1)) $display("FAIL ver_next_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0 + 1); else n_pass++;
        $display("good pkt after bad version: pkt_cnt=%0d", evt_pkt_cnt);
    endtask

    task automatic test_len_err();
        int base, p0, v0, l0;
        base = got_q.size(); p0 = evt_pkt_cnt; v0 = ver_pulses; l0 = len_pulses;
        evw.delete();
        evw.push_back({rec(2'b01, 3'd0, 8'h11, 19'd1), rec(2'b01, 3'd1, 8'h22, 19'd2)});
        evw.push_back({rec(2'b11, 3'd2, 8'h33, 19'd3), rec(2'b10, 3'd3, 8'h44, 19'd4)});
        build_pkt(16'h9999, 4'h1, 9'd5);
        send_pkt(1'b1);
        wait_cycles(10);
        n_checks++; if (got_q.size() - base != 4) $display("FAIL len_count: got %0d want 4", got_q.size() - base); else n_pass++;
        n_checks++; if (got_at(base) !== ev(2'b01, 3'd0, 8'h11, 32'h101)) $display("FAIL len_ev0: got %h want %h", got_at(base), ev(2'b01, 3'd0, 8'h11, 32'h101)); else n_pass++;
        n_checks++; if (got_at(base+3) !== ev(2'b10, 3'd3, 8'h44, 32'h104)) $display("FAIL len_ev3: got %h want %h", got_at(base+3), ev(2'b10, 3'd3, 8'h44, 32'h104)); else n_pass++;
        n_checks++; if (len_pulses - l0 != 1) $display("FAIL len_pulse: got %0d cycles want 1", len_pulses - l0); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'(p0)) $display("FAIL len_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0); else n_pass++;
        n_checks++; if (ver_pulses != v0) $display("FAIL len_ver_err: got %0d pulses want 0", ver_pulses - v0); else n_pass++;
        $display("short pkt: %0d events, len_err cycles=%0d", got_q.size() - base, len_pulses - l0);
        base = got_q.size();
        send_good_pkt();
        n_checks++; if (got_q.size() - base != 2) $display("FAIL len_next_count: got %0d want 2", got_q.size() - base); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'(p0 + 1)) $display("FAIL len_next_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0 + 1); else n_pass++;
        n_checks++; if (len_pulses - l0 != 1) $display("FAIL len_next_no_err: got %0d cycles want 1", len_pulses - l0); else n_pass++;
        $display("good pkt after short pkt: pkt_cnt=%0d", evt_pkt_cnt);
    endtask

    task automatic test_back_pressure();
        int base, p0;
        logic [31:0] r [2];
        logic [44:0] exp_ev;
        base = got_q.size(); p0 = evt_pkt_cnt;
        evw.delete();
        for (int j = 0; j < 10; j++) begin
            for (int h = 0; h < 2; h++) begin
                int k;
                k = 2 * j + h;
                r[h] = rec(2'((k % 3) + 1), 3'(k % 8), 8'(k * 3), 19'(k));
            end
            evw.push_back({r[0], r[1]});
        end
        build_pkt(16'h9999, 4'h1, 9'd20);
        evt_rdy = 1'b0;
        fork
            send_pkt(1'b1);
            begin
                int w;
                w = 0;
                while (in_rdy && w < 300) begin @(posedge clk); #1; w++; end
                n_checks++; if (in_rdy !== 1'b0) $display("FAIL bp_in_rdy_drop: got %b want 0", in_rdy); else n_pass++;
                wait_cycles(5);
                n_checks++; if (in_rdy !== 1'b0) $display("FAIL bp_in_rdy_held: got %b want 0", in_rdy); else n_pass++;
                n_checks++; if (evt_valid !== 1'b1) $display("FAIL bp_evt_valid: got %b want 1", evt_valid); else n_pass++;
                evt_rdy = 1'b1;
            end
        join
        wait_cycles(40);
        n_checks++; if (got_q.size() - base != 20) $display("FAIL bp_count: got %0d want 20", got_q.size() - base); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            exp_ev = ev(2'((k % 3) + 1), 3'(k % 8), 8'(k * 3), 32'h100 + 32'(k));
            n_checks++;
            if (got_at(base + k) !== exp_ev) $display("FAIL bp_ev%0d: got %h want %h", k, got_at(base + k), exp_ev);
            else n_pass++;
        end
        n_checks++; if (evt_pkt_cnt !== 16'(p0 + 1)) $display("FAIL bp_pkt_cnt: got %0d want %0d", evt_pkt_cnt, p0 + 1); else n_pass++;
        $display("back-pressure pkt: %0d events, pkt_cnt=%0d", got_q.size() - base, evt_pkt_cnt);
    endtask

    task automatic test_time_and_reset();
        int base;
        base = got_q.size();
        evw.delete();
        evw.push_back({ts(30'h3FFF_FFF0), rec(2'b01, 3'd5, 8'h5A, 19'h20)});
        build_pkt(16'h9999, 4'h1, 9'd2);
        send_pkt(1'b1);
        wait_cycles(10);
        n_checks++; if (got_q.size() - base != 1) $display("FAIL maxbase_count: got %0d want 1", got_q.size() - base); else n_pass++;
        n_checks++; if (got_at(base) !== ev(2'b01, 3'd5, 8'h5A, 32'h4000_0010)) $display("FAIL maxbase_time: got %h want %h", got_at(base), ev(2'b01, 3'd5, 8'h5A, 32'h4000_0010)); else n_pass++;
        $display("max-base pkt: evt_time=%h", got_at(base) & 45'hFFFF_FFFF);

        evt_rdy = 1'b0;
        evw.delete();
        evw.push_back({rec(2'b01, 3'd1, 8'h01, 19'd1), rec(2'b01, 3'd2, 8'h02, 19'd2)});
        evw.push_back({rec(2'b01, 3'd3, 8'h03, 19'd3), rec(2'b01, 3'd4, 8'h04, 19'd4)});
        build_pkt(16'h9999, 4'h1, 9'd6);
        send_pkt(1'b0);
        wait_cycles(2);
        n_checks++; if (evt_valid !== 1'b1) $display("FAIL mid_evts_valid: got %b want 1", evt_valid); else n_pass++;
        reset = 1'b1;
        wait_cycles(1);
        n_checks++; if (evt_valid !== 1'b0) $display("FAIL rst_fifo_empty: got %b want 0", evt_valid); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'd0) $display("FAIL rst_pkt_cnt: got %0d want 0", evt_pkt_cnt); else n_pass++;
        reset = 1'b0;
        evt_rdy = 1'b1;
        wait_cycles(1);
        n_checks++; if (in_rdy !== 1'b1) $display("FAIL rst_in_rdy: got %b want 1", in_rdy); else n_pass++;
        base = got_q.size();
        send_good_pkt();
        n_checks++; if (got_q.size() - base != 2) $display("FAIL rst_next_count: got %0d want 2", got_q.size() - base); else n_pass++;
        n_checks++; if (got_at(base + 1) !== ev(2'b10, 3'd7, 8'hAA, 32'h100)) $display("FAIL rst_next_ev1: got %h want %h", got_at(base + 1), ev(2'b10, 3'd7, 8'hAA, 32'h100)); else n_pass++;
        n_checks++; if (evt_pkt_cnt !== 16'd1) $display("FAIL rst_next_pkt_cnt: got %0d want 1", evt_pkt_cnt); else n_pass++;
        $display("pkt after mid-packet reset: pkt_cnt=%0d", evt_pkt_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_non_event();
        test_version();
        test_len_err();
        test_back_pressure();
        test_time_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
